mul_sched: RTL and testbench

- Command-level sequencer for the FrodoKEM matrix-multiply path.
- Accepts one multiply command (mode plus number of passes) over a valid/ready handshake.
- Drives mem_mode and the one-cycle calc_init pulse into the memory controller once per pass, times each pass with a cycle counter, then drains the systolic array.
- Signals completion to the top-level protocol FSM. Sits between that FSM and the memory controller / systolic array.

---
 rtl/mul_pkg.sv | 42 ++++
 rtl/mul_sched_cnt.sv | 40 ++++
 rtl/mul_sched.sv | 205 ++++++++++++++++++++
 tb/tb_mul_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the FrodoKEM matrix-multiply
//               command sequencer (mode encoding, scheduler states and the
//               per-pass timing derived from the matrix geometry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    // Multiply mode presented to the memory controller
    typedef enum logic [2:0] {
        MODE_IDLE = 3'd0,
        MODE_AS   = 3'd1,
        MODE_SA   = 3'd2,
        MODE_SB   = 3'd3,
        MODE_BS   = 3'd4
    } mode_t;

    // Command scheduler states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    localparam int FRODO_LINES  = 336;
    localparam int FRODO_BEATS  = 4;
    // One pass streams every line in FRODO_BEATS beats plus one wrap cycle
    localparam int PASS_CYC_DEF = FRODO_LINES * FRODO_BEATS + 1;

    // Only the four defined multiply modes may start a command
    function automatic logic mode_legal(input logic [2:0] m);
        return (m == MODE_AS) || (m == MODE_SA) || (m == MODE_SB) || (m == MODE_BS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_sched_cnt.sv
// ============================================================================
// Module      : mul_sched_cnt
// Description : Loadable down-counter with zero flag. Shared by the RUN and
//               DRAIN phases of the multiply scheduler.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_load, i_value - load strobe and value (load wins over dec)
//               i_dec           - decrement enable, stops at zero
//               o_zero          - counter currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sched_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mul_sched.sv
// ============================================================================
// Module      : mul_sched
// Description : Command-level sequencer for the FrodoKEM matrix-multiply path.
//               Accepts one command (mode + pass count), issues one calc_init
//               pulse per pass, times each pass, drains the systolic array and
//               reports completion.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               i_cmd_valid/o_cmd_ready         - command handshake
//               i_cmd_mode, i_cmd_passes        - command payload
//               i_abort                         - cancel the running command
//               o_mem_mode, o_calc_init         - memory controller controls
//               o_busy, o_pass_idx              - status
//               o_done, o_err, o_aborted        - one-cycle event pulses
//               o_perf_cycles                   - busy cycles of last command
// Options     : MUL_SCHED_PERF_EN - enables the busy-cycle performance counter;
//               when undefined o_perf_cycles is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sched
    import mul_pkg::*;
#(
    parameter int PASS_CYC  = PASS_CYC_DEF,
    parameter int DRAIN_CYC = 16,
    parameter int PASS_W    = 8,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_mode,
    input  logic [PASS_W-1:0] i_cmd_passes,
    input  logic              i_abort,
    output logic [2:0]        o_mem_mode,
    output logic              o_calc_init,
    output logic              o_busy,
    output logic [PASS_W-1:0] o_pass_idx,
    output logic              o_done,
    output logic              o_err,
    output logic              o_aborted,
    output logic [PERF_W-1:0] o_perf_cycles
);

    localparam int CNT_MAX = (PASS_CYC > DRAIN_CYC) ? PASS_CYC : DRAIN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The counter hits zero on the final cycle of a phase, so a phase of
    // N cycles is loaded with N-1.
    localparam logic [CNT_W-1:0] C_RUN_LOAD   = CNT_W'(PASS_CYC - 1);
    localparam logic [CNT_W-1:0] C_DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [2:0]        r_mode;
    logic [PASS_W-1:0] r_passes;
    logic [PASS_W-1:0] r_pass_idx;
    logic              r_err;
    logic              r_aborted;

    logic              w_accept;
    logic              w_legal;
    logic              w_last_pass;
    logic [PASS_W:0]   w_idx_inc;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_value;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_pass_inc;

    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_legal     = mode_legal(i_cmd_mode) && (i_cmd_passes != '0);
    // Compare one bit wider so pass_idx+1 cannot wrap before the compare
    assign w_idx_inc   = {1'b0, r_pass_idx} + (PASS_W+1)'(1);
    assign w_last_pass = (w_idx_inc >= {1'b0, r_passes});
    assign w_cnt_dec   = (r_state == S_RUN) || (r_state == S_DRAIN);

    mul_sched_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_dec   (w_cnt_dec),
        .o_zero  (w_cnt_zero)
    );

    // State register and command/pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_passes   <= '0;
            r_pass_idx <= '0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err     <= w_accept && !w_legal;
            // Abort is only meaningful once a command is in flight
            r_aborted <= i_abort && (r_state != S_IDLE);
            if (w_accept && w_legal) begin
                r_mode     <= i_cmd_mode;
                r_passes   <= i_cmd_passes;
                r_pass_idx <= '0;
            end else if (w_pass_inc) begin
                r_pass_idx <= r_pass_idx + PASS_W'(1);
            end
        end
    end

    // Next-state and counter control; abort outranks every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_value = '0;
        w_pass_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_cnt_load  = 1'b1;
                    w_cnt_value = C_RUN_LOAD;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero) begin
                    if (!w_last_pass) begin
                        w_state_nxt = S_INIT;
                        w_pass_inc  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_load  = 1'b1;
                        w_cnt_value = C_DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        o_cmd_ready = (r_state == S_IDLE);
        o_busy      = (r_state != S_IDLE);
        o_calc_init = (r_state == S_INIT);
        o_done      = (r_state == S_DONE);
        o_mem_mode  = (r_state == S_IDLE) ? MODE_IDLE : r_mode;
    end

    assign o_pass_idx = r_pass_idx;
    assign o_err      = r_err;
    assign o_aborted  = r_aborted;

`ifdef MUL_SCHED_PERF_EN
    logic [PERF_W-1:0] r_perf_cnt;
    logic [PERF_W-1:0] r_perf_out;
    logic [PERF_W-1:0] w_perf_nxt;

    // Saturating increment; the DONE-cycle value includes the DONE cycle itself
    assign w_perf_nxt = (&r_perf_cnt) ? r_perf_cnt : r_perf_cnt + PERF_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
            r_perf_out <= '0;
        end else begin
            r_perf_cnt <= (r_state == S_IDLE) ? '0 : w_perf_nxt;
            if ((r_state == S_DONE) && !i_abort) begin
                r_perf_out <= w_perf_nxt;
            end
        end
    end

    assign o_perf_cycles = r_perf_out;
`else
    assign o_perf_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// ============================================================================
// Module      : tb_mul_sched
// Description : Directed self-checking bench for mul_sched. A negedge monitor
//               logs calc_init/done/err/aborted events and busy cycles; the
//               stimulus thread compares them against hand-computed timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sched;

    localparam int PASS_W = 8;
    localparam int PERF_W = 32;
`ifdef MUL_SCHED_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [2:0]        i_cmd_mode = '0;
    logic [PASS_W-1:0] i_cmd_passes = '0;
    logic              i_abort = 1'b0;
    logic [2:0]        o_mem_mode;
    logic              o_calc_init;
    logic              o_busy;
    logic [PASS_W-1:0] o_pass_idx;
    logic              o_done;
    logic              o_err;
    logic              o_aborted;
    logic [PERF_W-1:0] o_perf_cycles;

    always #5 clk = ~clk;

    mul_sched u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_mode    (i_cmd_mode),
        .i_cmd_passes  (i_cmd_passes),
        .i_abort       (i_abort),
        .o_mem_mode    (o_mem_mode),
        .o_calc_init   (o_calc_init),
        .o_busy        (o_busy),
        .o_pass_idx    (o_pass_idx),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_aborted     (o_aborted),
        .o_perf_cycles (o_perf_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- event monitor ----------------
    int         cyc = 0;
    int         ci_cnt, done_cnt, busy_cnt, err_cnt, ab_cnt, mode_bad;
    int         done_t, err_t;
    int         ci_t   [8];
    int         ci_idx [8];
    logic [2:0] exp_mode = 3'd0;
    logic       clr_req = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (clr_req) begin
            ci_cnt = 0; done_cnt = 0; busy_cnt = 0; err_cnt = 0;
            ab_cnt = 0; mode_bad = 0; done_t = -1; err_t = -1;
        end
        if (o_calc_init) begin
            if (ci_cnt < 8) begin
                ci_t[ci_cnt]   = cyc;
                ci_idx[ci_cnt] = int'(o_pass_idx);
            end
            ci_cnt++;
        end
        if (o_done)    begin done_cnt++; done_t = cyc; end
        if (o_err)     begin err_cnt++;  err_t  = cyc; end
        if (o_aborted) ab_cnt++;
        if (o_busy) busy_cnt++;
        if (o_busy ? (o_mem_mode !== exp_mode) : (o_mem_mode !== 3'd0)) mode_bad++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clr();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    // Presents a command for one edge; returns the cycle number at drive time.
    // On return the monitor has already sampled the cycle after the accept.
    task automatic send(input logic [2:0] mode, input logic [PASS_W-1:0] passes, output int dc);
        i_cmd_valid  = 1'b1;
        i_cmd_mode   = mode;
        i_cmd_passes = passes;
        dc           = cyc;
        step();
        i_cmd_valid  = 1'b0;
    endtask

    logic [2:0]        ill_mode   [3] = '{3'd0, 3'd5, 3'd2};
    logic [PASS_W-1:0] ill_passes [3] = '{8'd1, 8'd1, 8'd0};

    initial begin
        int dc;

        // ---------------- reset ----------------
        steps(3);
        chk("rst_ready",    32'(o_cmd_ready),   32'd1);
        chk("rst_busy",     32'(o_busy),        32'd0);
        chk("rst_pulses",   32'({o_calc_init, o_done, o_err, o_aborted}), 32'd0);
        chk("rst_mem_mode", 32'(o_mem_mode),    32'd0);
        chk("rst_pass_idx", 32'(o_pass_idx),    32'd0);
        chk("rst_perf",     32'(o_perf_cycles), 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- single AS pass ----------------
        clr();
        exp_mode = 3'd1;
        send(3'd1, 8'd1, dc);
        steps(1400);
        chk("as_ci_cnt",    32'(ci_cnt),            32'd1);
        chk("as_ci_lat",    32'(ci_t[0] - dc),      32'd1);
        chk("as_done_cnt",  32'(done_cnt),          32'd1);
        chk("as_done_t",    32'(done_t - ci_t[0]),  32'd1362);
        chk("as_busy_cyc",  32'(busy_cnt),          32'd1363);
        chk("as_mode",      32'(mode_bad),          32'd0);
        chk("as_perf",      32'(o_perf_cycles),     PERF_ON ? 32'd1363 : 32'd0);
        chk("as_ready",     32'(o_cmd_ready),       32'd1);

        // ---------------- SB, three passes ----------------
        clr();
        exp_mode = 3'd3;
        send(3'd3, 8'd3, dc);
        steps(4100);
        chk("sb_ci_cnt",    32'(ci_cnt),             32'd3);
        chk("sb_ci1",       32'(ci_t[1] - ci_t[0]),  32'd1346);
        chk("sb_ci2",       32'(ci_t[2] - ci_t[0]),  32'd2692);
        chk("sb_idx0",      32'(ci_idx[0]),          32'd0);
        chk("sb_idx1",      32'(ci_idx[1]),          32'd1);
        chk("sb_idx2",      32'(ci_idx[2]),          32'd2);
        chk("sb_done_t",    32'(done_t - ci_t[0]),   32'd4054);
        chk("sb_done_cnt",  32'(done_cnt),           32'd1);
        chk("sb_mode",      32'(mode_bad),           32'd0);
        chk("sb_perf",      32'(o_perf_cycles),      PERF_ON ? 32'd4055 : 32'd0);

        // ---------------- illegal commands ----------------
        exp_mode = 3'd0;
        for (int k = 0; k < 3; k++) begin
            clr();
            send(ill_mode[k], ill_passes[k], dc);
            steps(3);
            chk("ill_err_cnt", 32'(err_cnt),    32'd1);
            chk("ill_err_t",   32'(err_t - dc), 32'd1);
            chk("ill_no_ci",   32'(ci_cnt),     32'd0);
            chk("ill_no_busy", 32'(busy_cnt),   32'd0);
            chk("ill_ready",   32'(o_cmd_ready), 32'd1);
        end

        // ---------------- abort mid-RUN of first of two passes ----------------
        clr();
        exp_mode = 3'd2;
        send(3'd2, 8'd2, dc);
        steps(499);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("ab_pulse",     32'(o_aborted),     32'd1);
        chk("ab_ready",     32'(o_cmd_ready),   32'd1);
        chk("ab_mem_mode",  32'(o_mem_mode),    32'd0);
        steps(3000);
        chk("ab_ci_cnt",    32'(ci_cnt),        32'd1);
        chk("ab_done_cnt",  32'(done_cnt),      32'd0);
        chk("ab_ab_cnt",    32'(ab_cnt),        32'd1);
        chk("ab_mode",      32'(mode_bad),      32'd0);
        chk("ab_perf_hold", 32'(o_perf_cycles), PERF_ON ? 32'd4055 : 32'd0);

        // ---------------- abort on last RUN cycle of a non-final pass ----------------
        clr();
        exp_mode = 3'd1;
        send(3'd1, 8'd2, dc);
        steps(1345);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abl_pulse",    32'(o_aborted),   32'd1);
        chk("abl_no_init",  32'(o_calc_init), 32'd0);
        steps(20);
        chk("abl_ci_cnt",   32'(ci_cnt),      32'd1);
        chk("abl_done_cnt", 32'(done_cnt),    32'd0);
        chk("abl_ab_cnt",   32'(ab_cnt),      32'd1);

        // ---------------- back-to-back, then async reset in DRAIN ----------------
        clr();
        exp_mode     = 3'd4;
        i_cmd_valid  = 1'b1;
        i_cmd_mode   = 3'd4;
        i_cmd_passes = 8'd1;
        for (int i = 0; i < 1500 && ci_cnt < 2; i++) step();
        i_cmd_valid  = 1'b0;
        chk("b2b_ci_cnt",   32'(ci_cnt),            32'd2);
        chk("b2b_done_cnt", 32'(done_cnt),          32'd1);
        chk("b2b_gap",      32'(ci_t[1] - done_t),  32'd2);
        chk("b2b_perf",     32'(o_perf_cycles),     PERF_ON ? 32'd1363 : 32'd0);
        steps(1351);
        chk("b2b_busy_drain", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready",    32'(o_cmd_ready),   32'd1);
        chk("arst_busy",     32'(o_busy),        32'd0);
        chk("arst_mem_mode", 32'(o_mem_mode),    32'd0);
        chk("arst_pass_idx", 32'(o_pass_idx),    32'd0);
        chk("arst_perf",     32'(o_perf_cycles), 32'd0);
        chk("arst_pulses",   32'({o_calc_init, o_done, o_err, o_aborted}), 32'd0);
        steps(2);
        rst_n = 1'b1;
        steps(30);
        chk("arst_no_done",  32'(done_cnt), 32'd1);
        chk("b2b_mode",      32'(mode_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
